// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage next-PC sequencer.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_MEM = 3'd2,
    STALL    = 3'd3,
    FLUSH    = 3'd4,
    HALT     = 3'd5
  } pc_state_t;

  localparam int FLUSH_W = 3;

endpackage

// File: rtl/pc_ctrl_next.sv
// Combinational next-PC priority mux: picks pc_load/pc_next and the next
// sequencer state from the current state, hazard inputs and flush counter.
module pc_ctrl_next
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INC      = 1,
  parameter int END_ADDR = 161
) (
  input  pc_state_t           state,
  input  logic                start,
  input  logic [ADDR_W-1:0]   pc_cur,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  input  logic                imem_ready,
  input  logic [FLUSH_W-1:0]  flush_cnt,
  output logic                pc_load,
  output logic [ADDR_W-1:0]   pc_next,
  output logic                branch_go,
  output pc_state_t           next_state
);

  always_comb begin
    next_state = state;
    pc_load    = 1'b0;
    pc_next    = pc_cur;
    branch_go  = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          pc_load    = 1'b1;
          pc_next    = branch_target;
          branch_go  = 1'b1;
          next_state = FLUSH;
        end else if (pc_cur == ADDR_W'(END_ADDR)) begin
          next_state = HALT;
        end else if (stall) begin
          next_state = STALL;
        end else if (!imem_ready) begin
          next_state = WAIT_MEM;
        end else begin
          pc_load = 1'b1;
          pc_next = pc_cur + ADDR_W'(INC);
        end
      end
      // A resolved branch outranks both stall and memory wait.
      STALL: begin
        if (branch_taken) begin
          pc_load    = 1'b1;
          pc_next    = branch_target;
          branch_go  = 1'b1;
          next_state = FLUSH;
        end else if (!stall) begin
          next_state = FETCH;
        end
      end
      WAIT_MEM: begin
        if (branch_taken) begin
          pc_load    = 1'b1;
          pc_next    = branch_target;
          branch_go  = 1'b1;
          next_state = FLUSH;
        end else if (imem_ready) begin
          next_state = FETCH;
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) next_state = FETCH;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage next-PC sequencer: holds state, flush counter and load count,
// and drives the pc register's load enable and input value.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int INC          = 1,
  parameter int END_ADDR     = 161,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              imem_ready,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              flush,
  output logic              halted,
  output logic [2:0]        state_o,
  output logic [31:0]       instr_count
);

  pc_state_t          state;
  pc_state_t          next_state;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               load_raw;
  logic [ADDR_W-1:0]  next_raw;
  logic               branch_go;

  pc_ctrl_next #(
    .ADDR_W   (ADDR_W),
    .INC      (INC),
    .END_ADDR (END_ADDR)
  ) u_next (
    .state         (state),
    .start         (start),
    .pc_cur        (pc_cur),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_ready    (imem_ready),
    .flush_cnt     (flush_cnt),
    .pc_load       (load_raw),
    .pc_next       (next_raw),
    .branch_go     (branch_go),
    .next_state    (next_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Counter is preloaded one short so FLUSH lasts exactly FLUSH_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (branch_go) begin
      flush_cnt <= FLUSH_W'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH && flush_cnt != '0) begin
      flush_cnt <= flush_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (pc_load && instr_count != 32'hFFFF_FFFF) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  // Reset forces the combinational outputs quiet without waiting for a clock.
  assign pc_load = load_raw & ~rst;
  assign pc_next = rst ? '0 : next_raw;
  assign flush   = (state == FLUSH);
  assign halted  = (state == HALT);
  assign state_o = state;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: table-driven vectors plus hand-written
// sequences for asynchronous reset and an 8-bit wraparound instance.
module tb_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc_cur;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        flush;
  logic        halted;
  logic [2:0]  state_o;
  logic [31:0] instr_count;

  logic        start8;
  logic [7:0]  pc_cur8;
  logic        stall8;
  logic        branch_taken8;
  logic [7:0]  branch_target8;
  logic        imem_ready8;
  logic        pc_load8;
  logic [7:0]  pc_next8;
  logic        flush8;
  logic        halted8;
  logic [2:0]  state_o8;
  logic [31:0] instr_count8;

  int checks;
  int errors;

  typedef struct {
    logic        start;
    logic [31:0] pc;
    logic        stall;
    logic        bt;
    logic [31:0] tgt;
    logic        ready;
    logic        load;
    logic [31:0] nxt;
    logic [2:0]  st;
    logic        fl;
    logic        hl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  pc_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pc_cur        (pc_cur),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_ready    (imem_ready),
    .pc_load       (pc_load),
    .pc_next       (pc_next),
    .flush         (flush),
    .halted        (halted),
    .state_o       (state_o),
    .instr_count   (instr_count)
  );

  pc_ctrl #(
    .ADDR_W       (8),
    .INC          (1),
    .END_ADDR     (100),
    .FLUSH_CYCLES (2)
  ) dut8 (
    .clk           (clk),
    .rst           (rst),
    .start         (start8),
    .pc_cur        (pc_cur8),
    .stall         (stall8),
    .branch_taken  (branch_taken8),
    .branch_target (branch_target8),
    .imem_ready    (imem_ready8),
    .pc_load       (pc_load8),
    .pc_next       (pc_next8),
    .flush         (flush8),
    .halted        (halted8),
    .state_o       (state_o8),
    .instr_count   (instr_count8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic s, input logic [31:0] pc, input logic stl,
                              input logic bt, input logic [31:0] tgt, input logic rdy,
                              input logic ld, input logic [31:0] nx, input logic [2:0] st,
                              input logic fl, input logic hl, input logic [31:0] cnt);
    vec_t v;
    v.start = s;  v.pc = pc;   v.stall = stl; v.bt = bt;  v.tgt = tgt; v.ready = rdy;
    v.load  = ld; v.nxt = nx;  v.st = st;     v.fl = fl;  v.hl = hl;   v.cnt = cnt;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start         = v.start;
    pc_cur        = v.pc;
    stall         = v.stall;
    branch_taken  = v.bt;
    branch_target = v.tgt;
    imem_ready    = v.ready;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkVal({tag, ".pc_load"},     {31'd0, pc_load}, {31'd0, v.load});
    checkVal({tag, ".pc_next"},     pc_next, v.nxt);
    checkVal({tag, ".state_o"},     {29'd0, state_o}, {29'd0, v.st});
    checkVal({tag, ".flush"},       {31'd0, flush}, {31'd0, v.fl});
    checkVal({tag, ".halted"},      {31'd0, halted}, {31'd0, v.hl});
    checkVal({tag, ".instr_count"}, instr_count, v.cnt);
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput(vecs[i], i);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
    pc_cur = 32'd7; branch_target = 32'd0;
    start8 = 1'b0; stall8 = 1'b0; branch_taken8 = 1'b0; imem_ready8 = 1'b1;
    pc_cur8 = 8'd255; branch_target8 = 8'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkVal("reset.pc_load", {31'd0, pc_load}, 32'd0);
    checkVal("reset.pc_next", pc_next, 32'd0);
    checkVal("reset.state_o", {29'd0, state_o}, 32'd0);
    checkVal("reset.flush", {31'd0, flush}, 32'd0);
    checkVal("reset.halted", {31'd0, halted}, 32'd0);
    checkVal("reset.instr_count", instr_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int split;
    checks = 0;
    errors = 0;

    //          st pc   stl bt tgt ry  ld nxt  st fl hl cnt
    vecs.push_back(mk(1, 0,   0, 0, 0,  1,  0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 0,  1,  1, 1,   1, 0, 0, 0));
    vecs.push_back(mk(0, 1,   0, 0, 0,  1,  1, 2,   1, 0, 0, 1));
    vecs.push_back(mk(0, 2,   0, 0, 0,  1,  1, 3,   1, 0, 0, 2));
    vecs.push_back(mk(0, 3,   0, 0, 0,  1,  1, 4,   1, 0, 0, 3));
    vecs.push_back(mk(0, 10,  0, 1, 40, 1,  1, 40,  1, 0, 0, 4));
    vecs.push_back(mk(0, 40,  0, 0, 0,  1,  0, 40,  4, 1, 0, 5));
    vecs.push_back(mk(0, 40,  0, 1, 99, 1,  0, 40,  4, 1, 0, 5));
    vecs.push_back(mk(0, 40,  0, 0, 0,  1,  1, 41,  1, 0, 0, 5));
    vecs.push_back(mk(0, 5,   1, 0, 0,  1,  0, 5,   1, 0, 0, 6));
    vecs.push_back(mk(0, 5,   1, 0, 0,  1,  0, 5,   3, 0, 0, 6));
    vecs.push_back(mk(0, 5,   1, 1, 20, 1,  1, 20,  3, 0, 0, 6));
    vecs.push_back(mk(0, 20,  0, 0, 0,  1,  0, 20,  4, 1, 0, 7));
    vecs.push_back(mk(0, 20,  0, 0, 0,  1,  0, 20,  4, 1, 0, 7));
    vecs.push_back(mk(0, 20,  0, 0, 0,  0,  0, 20,  1, 0, 0, 7));
    vecs.push_back(mk(0, 20,  0, 0, 0,  0,  0, 20,  2, 0, 0, 7));
    vecs.push_back(mk(0, 20,  0, 0, 0,  0,  0, 20,  2, 0, 0, 7));
    vecs.push_back(mk(0, 20,  0, 0, 0,  0,  0, 20,  2, 0, 0, 7));
    vecs.push_back(mk(0, 20,  0, 0, 0,  1,  0, 20,  2, 0, 0, 7));
    vecs.push_back(mk(0, 20,  0, 0, 0,  1,  1, 21,  1, 0, 0, 7));
    vecs.push_back(mk(0, 21,  0, 0, 0,  0,  0, 21,  1, 0, 0, 8));
    vecs.push_back(mk(0, 21,  1, 0, 0,  1,  0, 21,  2, 0, 0, 8));
    vecs.push_back(mk(0, 21,  1, 0, 0,  1,  0, 21,  1, 0, 0, 8));
    vecs.push_back(mk(0, 21,  0, 0, 0,  1,  0, 21,  3, 0, 0, 8));
    vecs.push_back(mk(0, 21,  0, 0, 0,  0,  0, 21,  1, 0, 0, 8));
    vecs.push_back(mk(0, 21,  0, 1, 30, 0,  1, 30,  2, 0, 0, 8));
    vecs.push_back(mk(0, 30,  0, 0, 0,  1,  0, 30,  4, 1, 0, 9));
    vecs.push_back(mk(0, 30,  0, 0, 0,  1,  0, 30,  4, 1, 0, 9));
    vecs.push_back(mk(0, 30,  0, 0, 0,  1,  1, 31,  1, 0, 0, 9));
    vecs.push_back(mk(0, 161, 1, 0, 0,  0,  0, 161, 1, 0, 0, 10));
    vecs.push_back(mk(1, 161, 0, 0, 0,  1,  0, 161, 5, 0, 1, 10));
    vecs.push_back(mk(1, 161, 0, 1, 50, 1,  0, 161, 5, 0, 1, 10));
    split = vecs.size();
    vecs.push_back(mk(1, 0,   0, 0, 0,   1, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 161, 1, 1, 161, 1, 0, 0, 0));
    vecs.push_back(mk(0, 161, 0, 0, 0,   1, 0, 161, 4, 1, 0, 1));
    vecs.push_back(mk(0, 161, 0, 0, 0,   1, 0, 161, 4, 1, 0, 1));
    vecs.push_back(mk(0, 161, 0, 0, 0,   1, 0, 161, 1, 0, 0, 1));
    vecs.push_back(mk(0, 161, 0, 0, 0,   1, 0, 161, 5, 0, 1, 1));

    $display("[TB] main sequence");
    doReset();
    runVectors(0, split - 1);

    // Asynchronous reset out of HALT, applied between clock edges.
    #1 rst = 1'b1;
    #1;
    checkVal("async_halt.halted", {31'd0, halted}, 32'd0);
    checkVal("async_halt.state_o", {29'd0, state_o}, 32'd0);
    checkVal("async_halt.pc_next", pc_next, 32'd0);

    $display("[TB] branch to end address");
    doReset();
    runVectors(split, vecs.size() - 1);

    $display("[TB] reset mid-flush");
    doReset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; pc_cur = 32'd10; branch_taken = 1'b1; branch_target = 32'd40;
    @(negedge clk);
    branch_taken = 1'b0; pc_cur = 32'd40;
    #2;
    checkVal("midflush.flush_before", {31'd0, flush}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkVal("midflush.flush_after", {31'd0, flush}, 32'd0);
    checkVal("midflush.state_o", {29'd0, state_o}, 32'd0);
    checkVal("midflush.instr_count", instr_count, 32'd0);

    $display("[TB] 8-bit wraparound");
    doReset();
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    #2;
    checkVal("wrap.state_o", {29'd0, state_o8}, 32'd1);
    checkVal("wrap.pc_load", {31'd0, pc_load8}, 32'd1);
    checkVal("wrap.pc_next", {24'd0, pc_next8}, 32'd0);
    @(negedge clk);
    #2;
    checkVal("wrap.instr_count", instr_count8, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
